// File: rtl/multiplexer_nto1_pipelined.sv
// N-to-1 multiplexer with a one-entry registered output stage and valid/ready flow control.
// Define MUX_ROUND_ROBIN_EN to add a `mode` port selecting round-robin arbitration over valid channels.
module multiplexer_nto1_pipelined #(
   parameter int WIDTH     = 32,
   parameter int INPUTS    = 4,
   parameter int SEL_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [INPUTS*WIDTH-1:0]  inputs,
   input  logic [INPUTS-1:0]        input_valid,
   output logic [INPUTS-1:0]        input_ready,
   input  logic [SEL_WIDTH-1:0]     selector,
`ifdef MUX_ROUND_ROBIN_EN
   input  logic                     mode,
`endif
   output logic [WIDTH-1:0]         output0,
   output logic                     output_valid,
   input  logic                     output_ready,
   output logic [SEL_WIDTH-1:0]     output_source
);

   // Handshake: a channel word transfers on a rising edge where input_valid[i] && input_ready[i];
   // the output word transfers on a rising edge where output_valid && output_ready.
   logic [WIDTH-1:0]     data_q, data_d;
   logic [SEL_WIDTH-1:0] src_q, src_d;
   logic                 valid_q, valid_d;

   logic [SEL_WIDTH-1:0] grant;
   logic                 grant_valid;
   logic                 grant_in_range;
   logic [WIDTH-1:0]     grant_data;
   logic                 can_accept;
   logic                 load;

`ifdef MUX_ROUND_ROBIN_EN
   logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
   logic                 found;
`endif

   always_comb begin
      grant          = '0;
      grant_valid    = 1'b0;
      grant_in_range = 1'b0;
`ifdef MUX_ROUND_ROBIN_EN
      found = 1'b0;
      if (mode) begin
         // Search pointer, pointer+1, ... wrapping at INPUTS; the first valid channel wins.
         for (int k = 0; k < INPUTS; k++) begin
            for (int i = 0; i < INPUTS; i++) begin
               if (!found && input_valid[i] && (i == ((int'(ptr_q) + k) % INPUTS))) begin
                  found = 1'b1;
                  grant = SEL_WIDTH'(i);
               end
            end
         end
         grant_valid    = |input_valid;
         grant_in_range = found;
      end else begin
         for (int i = 0; i < INPUTS; i++) begin
            if (int'(selector) == i) begin
               grant          = SEL_WIDTH'(i);
               grant_in_range = 1'b1;
               grant_valid    = input_valid[i];
            end
         end
      end
`else
      // An out-of-range selector matches no channel, leaving grant_valid low.
      for (int i = 0; i < INPUTS; i++) begin
         if (int'(selector) == i) begin
            grant          = SEL_WIDTH'(i);
            grant_in_range = 1'b1;
            grant_valid    = input_valid[i];
         end
      end
`endif
   end

   always_comb begin
      grant_data  = '0;
      input_ready = '0;
      can_accept  = !valid_q || output_ready;
      load        = can_accept && grant_valid;
      for (int i = 0; i < INPUTS; i++) begin
         if (grant_in_range && (grant == SEL_WIDTH'(i))) begin
            grant_data     = inputs[i*WIDTH +: WIDTH];
            input_ready[i] = can_accept;
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      src_d   = src_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = grant_data;
         src_d   = grant;
         valid_d = 1'b1;
      end else if (valid_q && output_ready) begin
         valid_d = 1'b0;
      end
   end

`ifdef MUX_ROUND_ROBIN_EN
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = ((32'(grant) + 32'd1) >= 32'(INPUTS)) ? '0 : (grant + SEL_WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         src_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         src_q   <= src_d;
         valid_q <= valid_d;
      end
   end

   assign output0       = data_q;
   assign output_source = src_q;
   assign output_valid  = valid_q;

endmodule

// File: tb/tb_multiplexer_nto1_pipelined.sv
// Self-checking bench for multiplexer_nto1_pipelined (direct-select build, 3 channels of 32 bits).
module tb_multiplexer_nto1_pipelined;

   localparam int WIDTH     = 32;
   localparam int INPUTS    = 3;
   localparam int SEL_WIDTH = 2;

   logic                    clk;
   logic                    rst_n;
   logic [WIDTH-1:0]        ch [INPUTS];
   logic [INPUTS*WIDTH-1:0] inputs_bus;
   logic [INPUTS-1:0]       in_valid;
   logic [INPUTS-1:0]       in_ready;
   logic [SEL_WIDTH-1:0]    sel;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_WIDTH-1:0]    out_src;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: contents of the one-entry output register plus the words it holds.
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   int               m_src;
   logic [WIDTH-1:0] exp_q[$];

   for (genvar g = 0; g < INPUTS; g++) begin : g_pack
      assign inputs_bus[g*WIDTH +: WIDTH] = ch[g];
   end

   multiplexer_nto1_pipelined #(
      .WIDTH(WIDTH), .INPUTS(INPUTS), .SEL_WIDTH(SEL_WIDTH)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .inputs(inputs_bus),
      .input_valid(in_valid),
      .input_ready(in_ready),
      .selector(sel),
      .output0(out_data),
      .output_valid(out_valid),
      .output_ready(out_ready),
      .output_source(out_src)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      exp_q.delete();
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
      check_eq({tag, "_data"},  64'(out_data),  64'(m_data));
      check_eq({tag, "_src"},   64'(out_src),   64'(m_src));
   endtask

   // One clock of traffic: inputs must already be driven; checks ready, the drained word and the new register contents.
   task automatic step(input string tag);
      int               s;
      logic             can_acc;
      logic             gv;
      logic [INPUTS-1:0] exp_ir;
      logic [WIDTH-1:0] w;
      #1;
      s       = int'(sel);
      can_acc = !m_valid || out_ready;
      gv      = (s < INPUTS) ? in_valid[s] : 1'b0;
      exp_ir  = (s < INPUTS && can_acc) ? INPUTS'(1 << s) : '0;
      check_eq({tag, "_ready"}, 64'(in_ready), 64'(exp_ir));
      if (m_valid && out_ready) begin
         w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check_eq({tag, "_drain"}, 64'(out_data), 64'(w));
      end
      if (can_acc && gv) begin
         m_valid = 1'b1;
         m_data  = ch[s];
         m_src   = s;
         exp_q.push_back(ch[s]);
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   task automatic drive(input logic [WIDTH-1:0] c0, input logic [WIDTH-1:0] c1, input logic [WIDTH-1:0] c2,
                        input logic [INPUTS-1:0] v, input logic [SEL_WIDTH-1:0] s, input logic ordy);
      ch[0]     = c0;
      ch[1]     = c1;
      ch[2]     = c2;
      in_valid  = v;
      sel       = s;
      out_ready = ordy;
   endtask

   initial begin
      rst_n = 1'b0;
      drive('0, '0, '0, '0, '0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("reset");

      // Direct select of ch0 then ch1
      drive(32'd111, 32'd222, 32'd999, 3'b111, 2'd0, 1'b1);
      step("sel0");
      check_eq("sel0_const", 64'(out_data), 64'd111);
      sel = 2'd1;
      step("sel1");
      check_eq("sel1_const", 64'(out_data), 64'd222);
      check_eq("sel1_src", 64'(out_src), 64'd1);

      // Backpressure: word held, nothing accepted while stalled, then back-to-back load
      sel = 2'd0;
      step("bp_load");
      out_ready = 1'b0;
      ch[0]     = 32'd333;
      for (int i = 0; i < 3; i++) begin
         step("bp_hold");
         check_eq("bp_hold_ready", 64'(in_ready), 64'd0);
      end
      check_eq("bp_held_const", 64'(out_data), 64'd111);
      out_ready = 1'b1;
      step("bp_release");
      check_eq("bp_release_const", 64'(out_data), 64'd333);
      check_eq("bp_release_valid", 64'(out_valid), 64'd1);

      // Out-of-range selector: current word drains, nothing new loads
      out_ready = 1'b0;
      sel       = 2'd3;
      step("oor_hold");
      out_ready = 1'b1;
      step("oor_drain");
      check_eq("oor_valid_const", 64'(out_valid), 64'd0);
      check_eq("oor_data_const", 64'(out_data), 64'd333);
      step("oor_idle");

      // Asynchronous reset while a word is held
      sel       = 2'd1;
      out_ready = 1'b0;
      step("ar_load");
      check_eq("ar_loaded_const", 64'(out_data), 64'd222);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("ar_async");
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("ar_no_load_in_reset");
      #2 rst_n = 1'b1;
      step("ar_first_load");

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < INPUTS; i++) ch[i] = $urandom;
         in_valid  = INPUTS'($urandom_range(0, 7));
         sel       = SEL_WIDTH'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
